// File: rtl/bram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_loader
//  Purpose  : Serial-to-BRAM boot loader. Parses framed write packets from a
//             byte stream and turns each payload byte into a single
//             byte-strobed write on the boot RAM data port.
//             Frame: A5, ADDR[4] (LE), LEN[2] (LE), LEN payload bytes, [CKSUM]
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             rx_vld/rx_dat   - input byte stream (transfer = rx_vld & rx_rdy)
//             rx_rdy          - loader can take a byte this cycle
//             dcs/dwe/dwst    - BRAM chip-select, write enable, one-hot strobe
//             dadrs/din       - BRAM byte address, byte replicated on all lanes
//             busy            - frame in progress
//             done/err        - one-cycle end-of-frame status pulses
//  Config   : LOADER_CKSUM_EN - when defined, frames carry a trailing CKSUM
//             byte; the 8-bit sum of ADDR, LEN, payload and CKSUM must be 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_loader #(
  parameter int              XLEN = 32,
  parameter logic [XLEN-1:0] BASE = XLEN'(32'hf0000000),
  parameter int              WIN  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_vld,
  input  logic [7:0]            rx_dat,
  output logic                  rx_rdy,
  output logic                  dcs,
  output logic                  dwe,
  output logic [XLEN/8-1:0]     dwst,
  output logic [XLEN-1:0]       dadrs,
  output logic [XLEN-1:0]       din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int              NB        = XLEN / 8;
  localparam int              LB        = $clog2(NB);
  localparam logic [XLEN-1:0] WIN_W     = XLEN'(WIN);
  localparam logic [NB-1:0]   LANE0     = NB'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_WR   = 3'd4,
    S_CK   = 3'd5,
    S_END  = 3'd6
  } state_t;

  // State entered once the payload (or an empty LEN) has been consumed.
`ifdef LOADER_CKSUM_EN
  localparam state_t TAIL = S_CK;
`else
  localparam state_t TAIL = S_END;
`endif

  state_t          state_q,     state_d;
  logic [XLEN-1:0] addr_q,      addr_d;      // address of next payload byte
  logic [1:0]      idx_q,       idx_d;       // byte index within ADDR / LEN
  logic [7:0]      len_lo_q,    len_lo_d;
  logic [15:0]     rem_q,       rem_d;       // payload bytes still to come
  logic [XLEN-1:0] wr_addr_q,   wr_addr_d;
  logic [7:0]      wr_byte_q,   wr_byte_d;
  logic            wr_ok_q,     wr_ok_d;     // pending write lies in window
  logic            range_err_q, range_err_d; // sticky for the whole frame
  logic [7:0]      sum_q,       sum_d;

  logic            accept;
  logic            frame_bad;

  assign accept = rx_vld & rx_rdy;
  assign busy   = (state_q != S_IDLE);
  assign dadrs  = wr_addr_q;
  assign din    = {NB{wr_byte_q}};

`ifdef LOADER_CKSUM_EN
  assign frame_bad = range_err_q | (sum_q != 8'h00);
`else
  assign frame_bad = range_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    wr_addr_d   = wr_addr_q;
    wr_byte_d   = wr_byte_q;
    wr_ok_d     = wr_ok_q;
    range_err_d = range_err_q;
    sum_d       = sum_q;
    rx_rdy      = 1'b0;
    dcs         = 1'b0;
    dwe         = 1'b0;
    dwst        = '0;
    done        = 1'b0;
    err         = 1'b0;

    case (state_q)
      S_IDLE: begin
        rx_rdy = 1'b1;
        if (accept && rx_dat == 8'hA5) begin
          state_d     = S_ADDR;
          addr_d      = '0;
          idx_d       = 2'd0;
          range_err_d = 1'b0;
          sum_d       = 8'h00;
        end
      end

      S_ADDR: begin
        rx_rdy = 1'b1;
        if (accept) begin
          addr_d[{idx_q, 3'b000} +: 8] = rx_dat;
          sum_d = sum_q + rx_dat;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_LEN;
        end
      end

      S_LEN: begin
        rx_rdy = 1'b1;
        if (accept) begin
          sum_d = sum_q + rx_dat;
          if (!idx_q[0]) begin
            len_lo_d = rx_dat;
            idx_d    = idx_q + 2'd1;
          end else begin
            rem_d   = {rx_dat, len_lo_q};
            state_d = ({rx_dat, len_lo_q} == 16'd0) ? TAIL : S_DATA;
          end
        end
      end

      S_DATA: begin
        rx_rdy = 1'b1;
        if (accept) begin
          wr_addr_d = addr_q;
          wr_byte_d = rx_dat;
          // Modulo subtraction folds both "below BASE" and "wrapped past
          // 2^XLEN" into one unsigned compare.
          wr_ok_d   = (addr_q - BASE) < WIN_W;
          if ((addr_q - BASE) >= WIN_W) range_err_d = 1'b1;
          addr_d    = addr_q + XLEN'(1);
          rem_d     = rem_q - 16'd1;
          sum_d     = sum_q + rx_dat;
          state_d   = S_WR;
        end
      end

      S_WR: begin
        // Write pulse for the byte taken last cycle; input is held off.
        dcs     = wr_ok_q;
        dwe     = wr_ok_q;
        dwst    = wr_ok_q ? (LANE0 << wr_addr_q[LB-1:0]) : '0;
        state_d = (rem_q == 16'd0) ? TAIL : S_DATA;
      end

      S_CK: begin
        rx_rdy = 1'b1;
        if (accept) begin
          sum_d   = sum_q + rx_dat;
          state_d = S_END;
        end
      end

      S_END: begin
        err     = frame_bad;
        done    = ~frame_bad;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      idx_q       <= 2'd0;
      len_lo_q    <= 8'h00;
      rem_q       <= 16'd0;
      wr_addr_q   <= '0;
      wr_byte_q   <= 8'h00;
      wr_ok_q     <= 1'b0;
      range_err_q <= 1'b0;
      sum_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      wr_addr_q   <= wr_addr_d;
      wr_byte_q   <= wr_byte_d;
      wr_ok_q     <= wr_ok_d;
      range_err_q <= range_err_d;
      sum_q       <= sum_d;
    end
  end

endmodule
`default_nettype wire
